uart_cmd_dispatcher: RTL and testbench

Sequences decoded UART command frames into register writes on the DDS configuration bus. Sits between the multi-byte UART receiver (frame strobe plus 11 payload bytes) and the DDS channel register banks. Decodes the opcode and range-checks the channel, then issues one to four valid/ready writes per frame with a timeout guard. Holds one frame of lookahead so back-to-back frames are not lost.

---
 rtl/uart_cmd_dispatcher.sv | 209 ++++++++++++++++++++
 tb/tb_uart_cmd_dispatcher.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher: turns decoded UART command frames into DDS config-bus
// writes. Holds one active and one pending frame; each frame issues 1..4
// valid/ready writes with a per-write timeout guard.
// Optional: define UART_CMD_STATS_EN for live frame_cnt / err_cnt counters;
// without it both are tied to 0.
module uart_cmd_dispatcher #(
  parameter int NUM_CH  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,   // active-high synchronous reset
  input  logic        recv_done,
  input  logic [7:0]  rev_data0,
  input  logic [7:0]  rev_data1,
  input  logic [7:0]  rev_data2,
  input  logic [7:0]  rev_data3,
  input  logic [7:0]  rev_data4,
  input  logic [7:0]  rev_data5,
  input  logic [7:0]  rev_data6,
  input  logic [7:0]  rev_data7,
  input  logic [7:0]  rev_data8,
  input  logic [7:0]  rev_data9,
  input  logic [7:0]  rev_data10,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [7:0]  cfg_addr,
  output logic [31:0] cfg_wdata,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic        frame_drop,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  ch;
    logic [31:0] freq;
    logic [15:0] phase;
    logic [15:0] amp;
    logic [7:0]  wave;
  } frame_t;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ISSUE, S_DONE, S_ERR} state_t;

  state_t        state;
  frame_t        act, pend, in_frame;
  logic          pend_vld;
  logic [1:0]    widx, widx_nxt, widx_last;
  logic [TW-1:0] wait_cnt;
  logic          fin, op_ok, ch_ok, dec_err, to_err;
  logic          cap_act, cap_pend, drop_now;

  // register number of write 'idx' for a given opcode
  function automatic logic [3:0] wr_reg(input logic [7:0] op, input logic [1:0] idx);
    case (op)
      8'h01:   wr_reg = 4'h0;
      8'h02:   wr_reg = 4'h1;
      8'h03:   wr_reg = 4'h2;
      8'h04:   wr_reg = {2'b00, idx};
      8'h05:   wr_reg = 4'hF;
      default: wr_reg = 4'h0;
    endcase
  endfunction

  // write data for a register, narrow fields zero-extended
  function automatic logic [31:0] wr_data(input frame_t f, input logic [3:0] r);
    case (r)
      4'h0:    wr_data = f.freq;
      4'h1:    wr_data = {16'h0, f.phase};
      4'h2:    wr_data = {16'h0, f.amp};
      4'h3:    wr_data = {24'h0, f.wave};
      4'hF:    wr_data = 32'h1;
      default: wr_data = 32'h0;
    endcase
  endfunction

  // assemble the incoming payload into a frame record
  always_comb begin
    in_frame       = '0;
    in_frame.op    = rev_data0;
    in_frame.ch    = rev_data1;
    in_frame.freq  = {rev_data2, rev_data3, rev_data4, rev_data5};
    in_frame.phase = {rev_data6, rev_data7};
    in_frame.amp   = {rev_data8, rev_data9};
    in_frame.wave  = rev_data10;
  end

  // frame routing and error detection; in DONE/ERR the pending slot is being
  // emptied this edge, so a new frame may land there without a drop
  always_comb begin
    fin       = (state == S_DONE) || (state == S_ERR);
    op_ok     = (act.op >= 8'h01) && (act.op <= 8'h05);
    ch_ok     = act.ch < 8'(NUM_CH);
    dec_err   = (state == S_DECODE) && !(op_ok && ch_ok);
    to_err    = (state == S_ISSUE) && !cfg_ready && (wait_cnt == TW'(TIMEOUT));
    widx_last = (act.op == 8'h04) ? 2'd3 : 2'd0;
    widx_nxt  = widx + 2'd1;
    cap_act   = recv_done && ((state == S_IDLE) || (fin && !pend_vld));
    cap_pend  = recv_done && !cap_act && (!pend_vld || fin);
    drop_now  = recv_done && !cap_act && !cap_pend;
  end

  assign busy = (state != S_IDLE);

  // main sequencer: capture, decode, issue writes, report
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state      <= S_IDLE;
      act        <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      widx       <= '0;
      wait_cnt   <= '0;
      cfg_valid  <= 1'b0;
      cfg_addr   <= '0;
      cfg_wdata  <= '0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
      err_code   <= '0;
      frame_drop <= 1'b0;
    end else begin
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
      frame_drop <= drop_now;
      if (cap_pend) begin
        pend     <= in_frame;
        pend_vld <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (cap_act) begin
            act   <= in_frame;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_err) begin
            state    <= S_ERR;
            cmd_err  <= 1'b1;
            err_code <= op_ok ? 2'd2 : 2'd1;
          end else begin
            state     <= S_ISSUE;
            widx      <= '0;
            wait_cnt  <= '0;
            cfg_valid <= 1'b1;
            cfg_addr  <= {act.ch[3:0], wr_reg(act.op, 2'd0)};
            cfg_wdata <= wr_data(act, wr_reg(act.op, 2'd0));
          end
        end
        S_ISSUE: begin
          if (cfg_ready) begin
            wait_cnt <= '0;
            if (widx == widx_last) begin
              cfg_valid <= 1'b0;
              state     <= S_DONE;
              cmd_done  <= 1'b1;
            end else begin
              widx      <= widx_nxt;
              cfg_addr  <= {act.ch[3:0], wr_reg(act.op, widx_nxt)};
              cfg_wdata <= wr_data(act, wr_reg(act.op, widx_nxt));
            end
          end else if (to_err) begin
            cfg_valid <= 1'b0;
            state     <= S_ERR;
            cmd_err   <= 1'b1;
            err_code  <= 2'd3;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_DONE, S_ERR: begin
          if (pend_vld) begin
            act   <= pend;
            state <= S_DECODE;
            if (!cap_pend) pend_vld <= 1'b0;
          end else if (cap_act) begin
            act   <= in_frame;
            state <= S_DECODE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_CMD_STATS_EN
  // accepted-frame and error statistics, wrapping at 16 bits
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      frame_cnt <= frame_cnt + {15'd0, cap_act | cap_pend};
      err_cnt   <= err_cnt + {15'd0, dec_err | to_err} + {15'd0, drop_now};
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Directed bench for uart_cmd_dispatcher: full-frame write sequence, decode
// errors, timeout, pending/drop handling and mid-transfer reset.
module tb_uart_cmd_dispatcher;

  localparam int NUM_CH  = 2;
  localparam int TIMEOUT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        recv_done;
  logic [7:0]  d [11];
  logic        cfg_valid, cfg_ready;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        busy, cmd_done, cmd_err, frame_drop;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt, err_cnt;

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;
  int exp_ec = 0;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_dispatcher #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .recv_done(recv_done),
    .rev_data0(d[0]), .rev_data1(d[1]), .rev_data2(d[2]), .rev_data3(d[3]),
    .rev_data4(d[4]), .rev_data5(d[5]), .rev_data6(d[6]), .rev_data7(d[7]),
    .rev_data8(d[8]), .rev_data9(d[9]), .rev_data10(d[10]),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .err_code(err_code), .frame_drop(frame_drop), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // present a frame with recv_done high for the next edge
  task automatic put(input logic [7:0] op, input logic [7:0] ch, input logic [31:0] fr,
                     input logic [15:0] ph, input logic [15:0] am, input logic [7:0] wv);
    d[0] = op; d[1] = ch;
    d[2] = fr[31:24]; d[3] = fr[23:16]; d[4] = fr[15:8]; d[5] = fr[7:0];
    d[6] = ph[15:8]; d[7] = ph[7:0]; d[8] = am[15:8]; d[9] = am[7:0];
    d[10] = wv;
    recv_done = 1'b1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef UART_CMD_STATS_EN
    chk({tag, "_fcnt"}, {16'd0, frame_cnt}, exp_fc);
    chk({tag, "_ecnt"}, {16'd0, err_cnt}, exp_ec);
`else
    chk({tag, "_fcnt"}, {16'd0, frame_cnt}, 0);
    chk({tag, "_ecnt"}, {16'd0, err_cnt}, 0);
`endif
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b1;
    tick();
    tick();
    sys_rst_n = 1'b0;
    exp_fc = 0;
    exp_ec = 0;
  endtask

  initial begin
    int n;
    sys_rst_n = 1'b1; recv_done = 1'b0; cfg_ready = 1'b0;
    for (int i = 0; i < 11; i++) d[i] = 8'h00;

    // reset state
    tick(); tick();
    chk("rst_outs", {cfg_valid, busy, cmd_done, cmd_err, frame_drop, err_code}, 0);
    chk("rst_addr", cfg_addr, 0);
    chk("rst_wdata", cfg_wdata, 0);
    chk_cnt("rst");
    sys_rst_n = 1'b0;
    tick();

    // opcode 4, channel 1, ready held high: four back-to-back writes
    cfg_ready = 1'b1;
    put(8'h04, 8'h01, 32'h12345678, 16'hABCD, 16'h0FFF, 8'h02);
    tick(); recv_done = 1'b0; exp_fc++;
    chk("op4_dec_busy", busy, 1);
    chk("op4_dec_valid", cfg_valid, 0);
    tick();
    chk("op4_w0", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h10, 32'h12345678});
    tick();
    chk("op4_w1", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h11, 32'h0000ABCD});
    tick();
    chk("op4_w2", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h12, 32'h00000FFF});
    tick();
    chk("op4_w3", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h13, 32'h00000002});
    tick();
    chk("op4_done", {cfg_valid, cmd_done, cmd_err}, 3'b010);
    tick();
    chk("op4_idle", {busy, cmd_done}, 0);
    chk_cnt("op4");

    // opcode 5 (ctrl soft reset) on the last legal channel
    put(8'h05, 8'h01, 32'h0, 16'h0, 16'h0, 8'h0);
    tick(); recv_done = 1'b0; exp_fc++;
    tick();
    chk("op5_w", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h1F, 32'h1});
    tick();
    chk("op5_done", cmd_done, 1);
    tick();

    // illegal opcode
    put(8'h07, 8'h00, 32'h0, 16'h0, 16'h0, 8'h0);
    tick(); recv_done = 1'b0; exp_fc++; exp_ec++;
    chk("op7_dec_valid", cfg_valid, 0);
    tick();
    chk("op7_err", {cfg_valid, cmd_done, cmd_err, err_code}, {3'b001, 2'd1});
    tick();
    chk("op7_after", {busy, cmd_err, cfg_valid}, 0);

    // bad channel 5, then boundary channel NUM_CH
    put(8'h01, 8'h05, 32'h0, 16'h0, 16'h0, 8'h0);
    tick(); recv_done = 1'b0; exp_fc++; exp_ec++;
    tick();
    chk("ch5_err", {cfg_valid, cmd_err, err_code}, {2'b01, 2'd2});
    tick();
    put(8'h02, 8'h02, 32'h0, 16'h0, 16'h0, 8'h0);
    tick(); recv_done = 1'b0; exp_fc++; exp_ec++;
    tick();
    chk("ch2_err", {cfg_valid, cmd_err, err_code}, {2'b01, 2'd2});
    tick();
    chk("err_code_held", err_code, 2);
    chk_cnt("errs");

    // timeout with ready low
    do_reset();
    cfg_ready = 1'b0;
    put(8'h01, 8'h00, 32'hCAFE0001, 16'h0, 16'h0, 8'h0);
    tick(); recv_done = 1'b0; exp_fc++;
    tick();
    chk("to_w", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h00, 32'hCAFE0001});
    n = 0;
    while (cfg_valid && n < 200) begin
      n++;
      tick();
    end
    exp_ec++;
    chk("to_valid_len", n, TIMEOUT + 1);
    chk("to_err", {cfg_valid, cmd_err, err_code}, {2'b01, 2'd3});
    tick();
    chk("to_after", {busy, cmd_err, cfg_valid}, 0);
    chk_cnt("to");

    // three frames while the first stalls: third dropped, second follows with no idle
    put(8'h01, 8'h00, 32'hAAAA0001, 16'h0, 16'h0, 8'h0);
    tick(); exp_fc++;
    put(8'h02, 8'h01, 32'h0, 16'h1234, 16'h0, 8'h0);
    tick(); exp_fc++;
    chk("pd_a_valid", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h00, 32'hAAAA0001});
    chk("pd_no_drop", frame_drop, 0);
    put(8'h03, 8'h00, 32'h0, 16'h0, 16'h5555, 8'h0);
    tick(); exp_ec++;
    recv_done = 1'b0;
    chk("pd_drop", frame_drop, 1);
    chk("pd_a_hold", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h00, 32'hAAAA0001});
    cfg_ready = 1'b1;
    tick();
    chk("pd_a_done", {cfg_valid, cmd_done, frame_drop, busy}, 4'b0101);
    tick();
    chk("pd_b_decode", {busy, cfg_valid}, 2'b10);
    tick();
    chk("pd_b_w", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h11, 32'h00001234});
    tick();
    chk("pd_b_done", cmd_done, 1);
    tick();
    chk("pd_idle", {busy, cfg_valid}, 0);
    chk_cnt("pd");

    // reset in the middle of an opcode 4 sequence with a frame pending
    put(8'h04, 8'h00, 32'h11111111, 16'h2222, 16'h3333, 8'h44);
    tick();
    put(8'h01, 8'h01, 32'h99999999, 16'h0, 16'h0, 8'h0);
    tick(); recv_done = 1'b0;
    chk("rm_w0", {cfg_valid, cfg_addr}, {1'b1, 8'h00});
    tick();
    chk("rm_w1", {cfg_valid, cfg_addr, cfg_wdata}, {1'b1, 8'h01, 32'h00002222});
    sys_rst_n = 1'b1;
    tick();
    exp_fc = 0; exp_ec = 0;
    chk("rm_valid_drop", {cfg_valid, busy}, 0);
    sys_rst_n = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cfg_valid || busy) n++;
    end
    chk("rm_no_pending", n, 0);
    chk_cnt("rm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
